// File: rtl/eros_pwr_pkg.sv
// eros_pwr_pkg: shared types and default timing constants for the EROS power
// sequencer (eros_power_ctrl) and its ack synchronizer (eros_pwr_sync).
//   pwr_state_e       sequencer state, encoding visible on state_o
//   PWR_*_DEF         default parameter values
//   pwr_cnt_width()   width of a dwell counter able to reach max(a, b)
package eros_pwr_pkg;

  typedef enum logic [2:0] {
    ACTIVE      = 3'd0,
    CLK_OFF     = 3'd1,
    RET_ON      = 3'd2,
    GATE_WAIT   = 3'd3,
    SLEEP       = 3'd4,
    UNGATE_WAIT = 3'd5,
    RET_OFF     = 3'd6,
    CLK_ON      = 3'd7
  } pwr_state_e;

  localparam int unsigned PWR_N_BANKS_DEF     = 2;
  localparam int unsigned PWR_CG_SETTLE_DEF   = 4;
  localparam int unsigned PWR_ACK_TIMEOUT_DEF = 255;

  function automatic int unsigned pwr_cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/eros_pwr_sync.sv
// eros_pwr_sync: N-bit two-flop synchronizer with synchronous active-low reset.
// Used for the bank power-switch acknowledges when EROS_PWR_ACK_SYNC_EN is defined.
// Ports:
//   clk_i   in   destination clock
//   rst_ni  in   synchronous reset, active-low; both stages load RESET_VAL
//   d_i     in   WIDTH asynchronous inputs
//   q_o     out  WIDTH synchronized outputs (2 cycles latency)
module eros_pwr_sync #(
  parameter int unsigned           WIDTH     = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/eros_power_ctrl.sv
// eros_power_ctrl: power sequencer for the EROS top wrapper (always-on domain).
// Power-down: gate clock, apply retention, switch off selected banks, sleep.
// Wake: reverse the sequence and return to ACTIVE.
// Configuration macro: EROS_PWR_ACK_SYNC_EN -- when defined the bank acks pass a
// 2-flop synchronizer (reset '1), adding 2 cycles to each ack wait.
// Ports:
//   clk_i             in   always-on clock
//   rst_ni            in   synchronous reset, active-low
//   pwr_down_req_i    in   power-down request (level, sampled in ACTIVE)
//   wake_req_i        in   wake event (level or pulse)
//   bank_mask_i       in   banks affected by power-down
//   retentive_i       in   1 = retain bank, 0 = power bank off
//   en_o              out  clock enable to wrapper
//   pwrgate_no        out  power-switch off, active-low
//   pwrgate_ack_ni    in   power-switch ack, active-low
//   set_retentive_no  out  retention enable, active-low
//   busy_o            out  sequencer not in ACTIVE
//   timeout_o         out  one-cycle pulse on ack timeout
//   state_o           out  current state encoding
module eros_power_ctrl
  import eros_pwr_pkg::*;
#(
  parameter int unsigned N_BANKS     = PWR_N_BANKS_DEF,
  parameter int unsigned CG_SETTLE   = PWR_CG_SETTLE_DEF,
  parameter int unsigned ACK_TIMEOUT = PWR_ACK_TIMEOUT_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pwr_down_req_i,
  input  logic               wake_req_i,
  input  logic [N_BANKS-1:0] bank_mask_i,
  input  logic [N_BANKS-1:0] retentive_i,
  output logic               en_o,
  output logic [N_BANKS-1:0] pwrgate_no,
  input  logic [N_BANKS-1:0] pwrgate_ack_ni,
  output logic [N_BANKS-1:0] set_retentive_no,
  output logic               busy_o,
  output logic               timeout_o,
  output logic [2:0]         state_o
);

  localparam int unsigned    CNT_W    = pwr_cnt_width(CG_SETTLE, ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CG_LAST  = CNT_W'(CG_SETTLE - 1);
  localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [N_BANKS-1:0] ack_n;

`ifdef EROS_PWR_ACK_SYNC_EN
  eros_pwr_sync #(
    .WIDTH     (N_BANKS),
    .RESET_VAL ('1)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pwrgate_ack_ni),
    .q_o    (ack_n)
  );
`else
  assign ack_n = pwrgate_ack_ni;
`endif

  pwr_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_BANKS-1:0] gate_m_q, gate_m_d;
  logic [N_BANKS-1:0] ret_m_q, ret_m_d;
  logic               wake_pend_q, wake_pend_d;
  logic               en_q, en_d;
  logic [N_BANKS-1:0] pg_q, pg_d;
  logic [N_BANKS-1:0] sr_q, sr_d;
  logic               busy_q, busy_d;
  logic               tmo_q, tmo_d;
  logic               gates_off, gates_on;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ACTIVE;
      cnt_q       <= '0;
      gate_m_q    <= '0;
      ret_m_q     <= '0;
      wake_pend_q <= 1'b0;
      en_q        <= 1'b1;
      pg_q        <= '1;
      sr_q        <= '1;
      busy_q      <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gate_m_q    <= gate_m_d;
      ret_m_q     <= ret_m_d;
      wake_pend_q <= wake_pend_d;
      en_q        <= en_d;
      pg_q        <= pg_d;
      sr_q        <= sr_d;
      busy_q      <= busy_d;
      tmo_q       <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gate_m_d    = gate_m_q;
    ret_m_d     = ret_m_q;
    tmo_d       = 1'b0;
    // An empty gate mask satisfies both ack conditions trivially.
    gates_off   = (ack_n & gate_m_q) == '0;
    gates_on    = (ack_n & gate_m_q) == gate_m_q;

    case (state_q)
      ACTIVE: begin
        // Wake has priority over a simultaneous power-down request.
        if (pwr_down_req_i && !wake_req_i) begin
          state_d  = CLK_OFF;
          gate_m_d = bank_mask_i & ~retentive_i;
          ret_m_d  = bank_mask_i & retentive_i;
        end
      end
      CLK_OFF:     if (cnt_q == CG_LAST) state_d = RET_ON;
      RET_ON:      state_d = GATE_WAIT;
      GATE_WAIT: begin
        if (gates_off) begin
          state_d = SLEEP;
        end else if (cnt_q == ACK_LAST) begin
          tmo_d   = 1'b1;
          state_d = UNGATE_WAIT;
        end
      end
      SLEEP:       if (wake_pend_q) state_d = UNGATE_WAIT;
      UNGATE_WAIT: begin
        if (gates_on) begin
          state_d = RET_OFF;
        end else if (cnt_q == ACK_LAST) begin
          tmo_d   = 1'b1;
          state_d = RET_OFF;
        end
      end
      RET_OFF:     state_d = CLK_ON;
      CLK_ON:      if (cnt_q == CG_LAST) state_d = ACTIVE;
      default:     state_d = ACTIVE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    if (state_d == ACTIVE) begin
      wake_pend_d = 1'b0;
    end else begin
      wake_pend_d = wake_pend_q | ((state_q != ACTIVE) & wake_req_i);
    end

    // Outputs are decoded from the next state so the registered values line up
    // with state_o in the same cycle.
    en_d   = (state_d == ACTIVE) || (state_d == CLK_ON);
    pg_d   = ((state_d == GATE_WAIT) || (state_d == SLEEP)) ? ~gate_m_d : '1;
    sr_d   = ((state_d == RET_ON) || (state_d == GATE_WAIT) ||
              (state_d == SLEEP)  || (state_d == UNGATE_WAIT)) ? ~ret_m_d : '1;
    busy_d = (state_d != ACTIVE);
  end

  assign en_o             = en_q;
  assign pwrgate_no       = pg_q;
  assign set_retentive_no = sr_q;
  assign busy_o           = busy_q;
  assign timeout_o        = tmo_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_eros_power_ctrl.sv
// tb_eros_power_ctrl: bench for eros_power_ctrl with N_BANKS=2, CG_SETTLE=4,
// ACK_TIMEOUT=16; the wrapper ack is pwrgate_no delayed by 3 cycles.
module tb_eros_power_ctrl;

  localparam int NB = 2;
  localparam int CG = 4;
  localparam int TO = 16;
`ifdef EROS_PWR_ACK_SYNC_EN
  localparam int ACK_LAT = 5;
`else
  localparam int ACK_LAT = 3;
`endif

  localparam logic [2:0] S_ACTIVE  = 3'd0;
  localparam logic [2:0] S_CLK_OFF = 3'd1;
  localparam logic [2:0] S_RET_ON  = 3'd2;
  localparam logic [2:0] S_GATE    = 3'd3;
  localparam logic [2:0] S_SLEEP   = 3'd4;
  localparam logic [2:0] S_UNGATE  = 3'd5;
  localparam logic [2:0] S_RET_OFF = 3'd6;
  localparam logic [2:0] S_CLK_ON  = 3'd7;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          pwr_down_req_i;
  logic          wake_req_i;
  logic [NB-1:0] bank_mask_i;
  logic [NB-1:0] retentive_i;
  logic          en_o;
  logic [NB-1:0] pwrgate_no;
  logic [NB-1:0] pwrgate_ack_ni;
  logic [NB-1:0] set_retentive_no;
  logic          busy_o;
  logic          timeout_o;
  logic [2:0]    state_o;

  logic [3*NB-1:0] ack_pipe = '1;
  logic            ack_stuck = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ack_pipe <= {ack_pipe[2*NB-1:0], pwrgate_no};
  assign pwrgate_ack_ni = ack_stuck ? '1 : ack_pipe[3*NB-1:2*NB];

  eros_power_ctrl #(
    .N_BANKS     (NB),
    .CG_SETTLE   (CG),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .pwr_down_req_i   (pwr_down_req_i),
    .wake_req_i       (wake_req_i),
    .bank_mask_i      (bank_mask_i),
    .retentive_i      (retentive_i),
    .en_o             (en_o),
    .pwrgate_no       (pwrgate_no),
    .pwrgate_ack_ni   (pwrgate_ack_ni),
    .set_retentive_no (set_retentive_no),
    .busy_o           (busy_o),
    .timeout_o        (timeout_o),
    .state_o          (state_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view: {state, en, pwrgate_n, set_retentive_n, busy, timeout}
  function automatic logic [9:0] ev(input logic [2:0] st, input logic en,
                                    input logic [1:0] pg, input logic [1:0] sr,
                                    input logic tmo);
    return {st, en, pg, sr, (st != S_ACTIVE), tmo};
  endfunction

  task automatic check(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {state_o, en_o, pwrgate_no, set_retentive_no, busy_o, timeout_o};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Expected per-cycle trace of a power-down request issued in the current
  // (ACTIVE) cycle, built from phase durations; wake is pulsed in relative
  // cycle rw. With rst_sleep the run stops at the first SLEEP cycle and resets.
  task automatic run_seq(input string nm, input logic [1:0] mask, input logic [1:0] ret,
                         input logic stuck, input int rw, input logic rst_sleep);
    logic [9:0] q[$];
    logic [1:0] gm, rm;
    int dg, ds, du, s, stop;
    logic tmo;
    gm  = mask & ~ret;
    rm  = mask & ret;
    tmo = 1'b0;
    for (int i = 0; i < CG; i++) q.push_back(ev(S_CLK_OFF, 1'b0, 2'b11, 2'b11, 1'b0));
    q.push_back(ev(S_RET_ON, 1'b0, 2'b11, ~rm, 1'b0));
    dg = (gm == 2'b00) ? 1 : (stuck ? TO : ACK_LAT + 1);
    for (int i = 0; i < dg; i++) q.push_back(ev(S_GATE, 1'b0, ~gm, ~rm, 1'b0));
    s = CG + 2 + dg;
    if (gm != 2'b00 && stuck) begin
      tmo = 1'b1;
      du  = 1;
    end else begin
      ds = rw - s + 2;
      if (ds < 1) ds = 1;
      for (int i = 0; i < ds; i++) q.push_back(ev(S_SLEEP, 1'b0, ~gm, ~rm, 1'b0));
      du = (gm == 2'b00 || stuck) ? 1 : ACK_LAT + 1;
    end
    for (int i = 0; i < du; i++) q.push_back(ev(S_UNGATE, 1'b0, 2'b11, ~rm, (i == 0) ? tmo : 1'b0));
    q.push_back(ev(S_RET_OFF, 1'b0, 2'b11, 2'b11, 1'b0));
    for (int i = 0; i < CG; i++) q.push_back(ev(S_CLK_ON, 1'b1, 2'b11, 2'b11, 1'b0));
    for (int i = 0; i < 2; i++) q.push_back(ev(S_ACTIVE, 1'b1, 2'b11, 2'b11, 1'b0));

    stop = rst_sleep ? s : q.size();
    bank_mask_i    = mask;
    retentive_i    = ret;
    pwr_down_req_i = 1'b1;
    wake_req_i     = 1'b0;
    ack_stuck      = stuck;
    for (int r = 1; r <= stop; r++) begin
      tick();
      check($sformatf("%s r%0d", nm, r), q[r-1]);
      pwr_down_req_i = 1'b0;
      wake_req_i     = (r == rw);
      bank_mask_i    = 2'($urandom);
      retentive_i    = 2'($urandom);
    end
    wake_req_i = 1'b0;
    ack_stuck  = 1'b0;
    if (rst_sleep) begin
      rst_ni = 1'b0;
      tick();
      check({nm, " reset"}, ev(S_ACTIVE, 1'b1, 2'b11, 2'b11, 1'b0));
      rst_ni = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check({nm, " after"}, ev(S_ACTIVE, 1'b1, 2'b11, 2'b11, 1'b0));
    end
  endtask

  initial begin
    rst_ni         = 1'b0;
    pwr_down_req_i = 1'b0;
    wake_req_i     = 1'b0;
    bank_mask_i    = '0;
    retentive_i    = '0;
    tick();
    check("reset", ev(S_ACTIVE, 1'b1, 2'b11, 2'b11, 1'b0));
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("idle", ev(S_ACTIVE, 1'b1, 2'b11, 2'b11, 1'b0));

    run_seq("full", 2'b11, 2'b01, 1'b0, 20, 1'b0);
    run_seq("timeout", 2'b11, 2'b01, 1'b1, 1000, 1'b0);

    bank_mask_i    = 2'b11;
    retentive_i    = 2'b00;
    pwr_down_req_i = 1'b1;
    wake_req_i     = 1'b1;
    tick();
    check("simul0", ev(S_ACTIVE, 1'b1, 2'b11, 2'b11, 1'b0));
    pwr_down_req_i = 1'b0;
    wake_req_i     = 1'b0;
    tick();
    check("simul1", ev(S_ACTIVE, 1'b1, 2'b11, 2'b11, 1'b0));

    run_seq("wake_clkoff", 2'b10, 2'b00, 1'b0, 2, 1'b0);
    run_seq("rst_sleep", 2'b11, 2'b01, 1'b0, 1000, 1'b1);
    run_seq("empty", 2'b00, 2'b10, 1'b0, 10, 1'b0);
    run_seq("noret", 2'b01, 2'b10, 1'b0, 12, 1'b0);

    for (int k = 0; k < 24; k++) begin
      run_seq($sformatf("rnd%0d", k), 2'($urandom), 2'($urandom),
              ($urandom_range(0, 3) == 0), int'($urandom_range(1, 40)), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
